// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, write opcodes, mstatus layout and helpers
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    WOP_NOP = 2'b00,
    WOP_RW  = 2'b01,
    WOP_RS  = 2'b10,
    WOP_RC  = 2'b11
  } wop_e;

  // mstatus: only MIE/MPIE are stored; MPP is hardwired to machine mode
  localparam int          MSTATUS_MIE   = 3;
  localparam int          MSTATUS_MPIE  = 7;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } trap_cause_t;

  function automatic logic [31:0] csr_rmw(input wop_e op, input logic [31:0] old,
                                          input logic [31:0] src);
    case (op)
      WOP_RW:  return src;
      WOP_RS:  return old | src;
      WOP_RC:  return old & ~src;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_mfile_if.sv
// rtl/csr_mfile_if.sv - CSR read/write access bus between execute stage and CSR file
interface csr_mfile_if;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        illegal;
  logic        wen;
  logic [1:0]  wop;
  logic [11:0] waddr;
  logic [31:0] wsrc;

  modport master (output raddr, wen, wop, waddr, wsrc, input rdata, illegal);
  modport slave  (input raddr, wen, wop, waddr, wsrc, output rdata, illegal);
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with independently writable halves
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] cnt_d, cnt_q;

  // a write to either half wins over the increment and leaves the other half alone
  always_comb begin
    cnt_d = cnt_q;
    if (wen_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wen_hi) begin
      cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_mfile.sv
// rtl/csr_mfile.sv - machine-mode CSR file with trap/MRET sequencing and counters
module csr_mfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET  = 32'h0,
  parameter logic [31:0] MHARTID      = 32'h0,
  parameter bit          VECTORED     = 1'b0,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  csr_mfile_if.slave       bus,
  input  logic             trap_req,
  input  logic [31:0]      trap_cause,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      trap_tval,
  input  logic             mret_req,
  input  logic             instret_inc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mie_o
);

  localparam logic [31:0] MTVEC_MASK = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  typedef enum logic {ST_IDLE, ST_REDIR} redir_state_e;

  typedef struct packed {
    logic        hit;
    logic        ro;
    logic [31:0] val;
  } csr_rd_t;

  redir_state_e state_d, state_q;
  logic [31:0]  redirect_pc_d, redirect_pc_q;
  logic         mie_d, mie_q, mpie_d, mpie_q;
  logic [31:0]  mtvec_d, mtvec_q, mscratch_d, mscratch_q;
  logic [31:0]  mepc_d, mepc_q, mcause_d, mcause_q, mtval_d, mtval_q;
  logic [31:0]  mstatus_rd;
  logic [63:0]  mcycle, minstret;

  // assemble the architectural view of mstatus from the two stored bits
  always_comb begin
    mstatus_rd               = MSTATUS_FIXED;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
  end

  function automatic csr_rd_t lookup(input logic [11:0] addr);
    csr_rd_t r;
    r = '{hit: 1'b1, ro: 1'b0, val: 32'h0};
    case (addr)
      CSR_MSTATUS:   r.val = mstatus_rd;
      CSR_MTVEC:     r.val = mtvec_q;
      CSR_MSCRATCH:  r.val = mscratch_q;
      CSR_MEPC:      r.val = mepc_q;
      CSR_MCAUSE:    r.val = mcause_q;
      CSR_MTVAL:     r.val = mtval_q;
      CSR_MCYCLE:    begin r.hit = HAS_COUNTERS; r.val = mcycle[31:0];    end
      CSR_MCYCLEH:   begin r.hit = HAS_COUNTERS; r.val = mcycle[63:32];   end
      CSR_MINSTRET:  begin r.hit = HAS_COUNTERS; r.val = minstret[31:0];  end
      CSR_MINSTRETH: begin r.hit = HAS_COUNTERS; r.val = minstret[63:32]; end
      CSR_MVENDORID, CSR_MARCHID: r.ro = 1'b1;
      CSR_MHARTID:   begin r.ro = 1'b1; r.val = MHARTID; end
      default:       r.hit = 1'b0;
    endcase
    return r;
  endfunction

  csr_rd_t     rd_l, wr_l;
  logic        wr_req, wr_fire;
  logic [31:0] wr_new;
  trap_cause_t cause;
  logic [31:0] vec_base, trap_target;

  assign rd_l        = lookup(bus.raddr);
  assign wr_l        = lookup(bus.waddr);
  assign wr_req      = bus.wen && (bus.wop != WOP_NOP);
  // traps and MRET pre-empt any CSR instruction committing in the same cycle
  assign wr_fire     = wr_req && !trap_req && !mret_req && wr_l.hit && !wr_l.ro;
  assign wr_new      = csr_rmw(wop_e'(bus.wop), wr_l.val, bus.wsrc);
  assign bus.rdata   = rd_l.val;
  assign bus.illegal = !rd_l.hit || (wr_req && (!wr_l.hit || wr_l.ro));

  assign cause       = trap_cause_t'(trap_cause);
  assign vec_base    = {mtvec_q[31:2], 2'b00};
  assign trap_target = (VECTORED && mtvec_q[0] && cause.irq)
                     ? vec_base + ({1'b0, cause.code} << 2) : vec_base;

  // next-state for CSRs and the redirect register, trap > mret > write
  always_comb begin
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    state_d       = ST_IDLE;
    redirect_pc_d = redirect_pc_q;
    if (trap_req) begin
      mepc_d        = trap_pc & ~32'h3;
      mcause_d      = trap_cause;
      mtval_d       = trap_tval;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      state_d       = ST_REDIR;
      redirect_pc_d = trap_target;
    end else if (mret_req) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      state_d       = ST_REDIR;
      redirect_pc_d = mepc_q;
    end else if (wr_fire) begin
      case (bus.waddr)
        CSR_MSTATUS: begin
          mie_d  = wr_new[MSTATUS_MIE];
          mpie_d = wr_new[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_d    = wr_new & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_d = wr_new;
        CSR_MEPC:     mepc_d     = wr_new & ~32'h3;
        CSR_MCAUSE:   mcause_d   = wr_new;
        CSR_MTVAL:    mtval_d    = wr_new;
        default: ;
      endcase
    end
  end

  // CSR and redirect registers; reset clears the redirect pulse immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  if (HAS_COUNTERS) begin : g_cnt
    csr_counter64 u_mcycle (
      .clk    (clk),
      .rstn   (rstn),
      .inc    (1'b1),
      .wen_lo (wr_fire && (bus.waddr == CSR_MCYCLE)),
      .wen_hi (wr_fire && (bus.waddr == CSR_MCYCLEH)),
      .wdata  (wr_new),
      .count  (mcycle)
    );
    csr_counter64 u_minstret (
      .clk    (clk),
      .rstn   (rstn),
      .inc    (instret_inc),
      .wen_lo (wr_fire && (bus.waddr == CSR_MINSTRET)),
      .wen_hi (wr_fire && (bus.waddr == CSR_MINSTRETH)),
      .wdata  (wr_new),
      .count  (minstret)
    );
  end else begin : g_no_cnt
    assign mcycle   = '0;
    assign minstret = '0;
  end

  assign redirect_valid = (state_q == ST_REDIR);
  assign redirect_pc    = redirect_pc_q;
  assign mie_o          = mie_q;

endmodule

// File: tb/tb_csr_mfile.sv
// tb/tb_csr_mfile.sv - self-checking bench for csr_mfile against a word-level model
module tb_csr_mfile;

  localparam logic [31:0] HART = 32'h0000_0007;

  logic        clk;
  logic        rstn;
  logic        trap_req, mret_req, instret_inc;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        redirect_valid, mie_o;
  logic [31:0] redirect_pc;
  int          checks, errors;

  csr_mfile_if bus ();

  csr_mfile #(
    .MTVEC_RESET  (32'h0000_0100),
    .MHARTID      (HART),
    .VECTORED     (1'b1),
    .HAS_COUNTERS (1'b1)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .instret_inc    (instret_inc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mie_o          (mie_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: whole architectural words and 64-bit counters
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  logic [63:0] m_cycle, m_instret;
  logic        m_rv;
  logic [31:0] n_mstatus, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_rpc;
  logic [63:0] n_cycle, n_instret;
  logic        n_rv;
  logic [31:0] m_new;

  function automatic bit m_hit(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return (a == 12'hF11) || (a == 12'hF12) || (a == 12'hF14);
  endfunction

  function automatic logic [31:0] m_val(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal();
    return !m_hit(bus.raddr) ||
           (bus.wen && bus.wop != 2'b00 && (!m_hit(bus.waddr) || m_ro(bus.waddr)));
  endfunction

  // what the next clock edge must produce, from the architectural rules
  always_comb begin
    n_mstatus  = m_mstatus;
    n_mtvec    = m_mtvec;
    n_mscratch = m_mscratch;
    n_mepc     = m_mepc;
    n_mcause   = m_mcause;
    n_mtval    = m_mtval;
    n_cycle    = m_cycle + 64'd1;
    n_instret  = m_instret + (instret_inc ? 64'd1 : 64'd0);
    n_rv       = 1'b0;
    n_rpc      = m_rpc;
    m_new      = m_val(bus.waddr);
    case (bus.wop)
      2'b01:   m_new = bus.wsrc;
      2'b10:   m_new = m_val(bus.waddr) | bus.wsrc;
      2'b11:   m_new = m_val(bus.waddr) & ~bus.wsrc;
      default: ;
    endcase
    if (trap_req) begin
      n_rv      = 1'b1;
      n_rpc     = m_mtvec & 32'hFFFF_FFFC;
      if (m_mtvec[0] && trap_cause[31])
        n_rpc = n_rpc + (trap_cause & 32'h7FFF_FFFF) * 32'd4;
      n_mepc    = trap_pc & 32'hFFFF_FFFC;
      n_mcause  = trap_cause;
      n_mtval   = trap_tval;
      n_mstatus = m_mstatus[3] ? 32'h1880 : 32'h1800;
    end else if (mret_req) begin
      n_rv      = 1'b1;
      n_rpc     = m_mepc;
      n_mstatus = m_mstatus[7] ? 32'h1888 : 32'h1880;
    end else if (bus.wen && bus.wop != 2'b00 && m_hit(bus.waddr) && !m_ro(bus.waddr)) begin
      case (bus.waddr)
        12'h300: n_mstatus  = 32'h1800 | (m_new & 32'h88);
        12'h305: n_mtvec    = m_new & 32'hFFFF_FFFD;
        12'h340: n_mscratch = m_new;
        12'h341: n_mepc     = m_new & 32'hFFFF_FFFC;
        12'h342: n_mcause   = m_new;
        12'h343: n_mtval    = m_new;
        12'hB00: n_cycle    = {m_cycle[63:32], m_new};
        12'hB80: n_cycle    = {m_new, m_cycle[31:0]};
        12'hB02: n_instret  = {m_instret[63:32], m_new};
        12'hB82: n_instret  = {m_new, m_instret[31:0]};
        default: ;
      endcase
    end
  end

  // advance the model alongside the DUT
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mstatus  <= 32'h1800;
      m_mtvec    <= 32'h0000_0100;
      m_mscratch <= '0;
      m_mepc     <= '0;
      m_mcause   <= '0;
      m_mtval    <= '0;
      m_cycle    <= '0;
      m_instret  <= '0;
      m_rv       <= 1'b0;
      m_rpc      <= '0;
    end else begin
      m_mstatus  <= n_mstatus;
      m_mtvec    <= n_mtvec;
      m_mscratch <= n_mscratch;
      m_mepc     <= n_mepc;
      m_mcause   <= n_mcause;
      m_mtval    <= n_mtval;
      m_cycle    <= n_cycle;
      m_instret  <= n_instret;
      m_rv       <= n_rv;
      m_rpc      <= n_rpc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rstn) begin
      chk("cmp_rdata", bus.rdata, m_val(bus.raddr));
      chk("cmp_illegal", {31'd0, bus.illegal}, {31'd0, m_illegal()});
      chk("cmp_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      if (m_rv) chk("cmp_redirect_pc", redirect_pc, m_rpc);
      chk("cmp_mie", {31'd0, mie_o}, {31'd0, m_mstatus[3]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wen  = 1'b0;
    trap_req = 1'b0;
    mret_req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    bus.wen   = 1'b1;
    bus.wop   = op;
    bus.waddr = a;
    bus.wsrc  = d;
    cyc();
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.raddr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstn        = 1'b0;
    trap_req    = 1'b0;
    mret_req    = 1'b0;
    instret_inc = 1'b0;
    trap_cause  = '0;
    trap_pc     = '0;
    trap_tval   = '0;
    bus.raddr   = 12'h300;
    bus.wen     = 1'b0;
    bus.wop     = 2'b00;
    bus.waddr   = 12'h300;
    bus.wsrc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mhartid", 12'hF14, HART);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    cyc();
    rd("unmapped_rdata", 12'h7C0, 32'h0);
    chk("unmapped_illegal", {31'd0, bus.illegal}, 32'd1);

    wr(12'h340, 2'b01, 32'hA5A5_0000);
    rd("mscratch_rw", 12'h340, 32'hA5A5_0000);
    wr(12'h340, 2'b10, 32'h0000_00FF);
    rd("mscratch_rs", 12'h340, 32'hA5A5_00FF);
    wr(12'h340, 2'b11, 32'hA500_0000);
    rd("mscratch_rc", 12'h340, 32'h00A5_00FF);

    wr(12'h305, 2'b01, 32'h8000_1000);
    wr(12'h300, 2'b10, 32'h0000_0008);
    chk("mie_set", {31'd0, mie_o}, 32'd1);
    trap_req   = 1'b1;
    trap_pc    = 32'h8000_0106;
    trap_cause = 32'h0000_0002;
    trap_tval  = 32'h0000_DEAD;
    cyc();
    chk("trap_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("trap_redirect_pc", redirect_pc, 32'h8000_1000);
    rd("trap_mepc", 12'h341, 32'h8000_0104);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    mret_req = 1'b1;
    cyc();
    chk("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("mret_redirect_pc", redirect_pc, 32'h8000_0104);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    cyc();
    chk("redirect_pulse_end", {31'd0, redirect_valid}, 32'd0);

    wr(12'h305, 2'b01, 32'h8000_0003);
    rd("mtvec_bit1_mask", 12'h305, 32'h8000_0001);
    trap_req   = 1'b1;
    trap_cause = 32'h8000_0007;
    cyc();
    chk("vectored_pc", redirect_pc, 32'h8000_001C);
    rd("vectored_mcause", 12'h342, 32'h8000_0007);

    trap_req  = 1'b1;
    trap_cause = 32'h0000_000B;
    bus.wen   = 1'b1;
    bus.wop   = 2'b01;
    bus.waddr = 12'h340;
    bus.wsrc  = 32'h0000_0001;
    cyc();
    rd("trap_drops_write", 12'h340, 32'h00A5_00FF);
    mret_req  = 1'b1;
    bus.wen   = 1'b1;
    bus.wop   = 2'b01;
    bus.waddr = 12'h340;
    bus.wsrc  = 32'h0000_0002;
    cyc();
    rd("mret_drops_write", 12'h340, 32'h00A5_00FF);

    bus.wen   = 1'b1;
    bus.wop   = 2'b01;
    bus.waddr = 12'hF14;
    bus.wsrc  = 32'h0000_0009;
    bus.raddr = 12'h340;
    #1;
    chk("ro_write_illegal", {31'd0, bus.illegal}, 32'd1);
    cyc();
    rd("ro_write_ignored", 12'hF14, HART);
    wr(12'h341, 2'b01, 32'h1234_5677);
    rd("mepc_mask", 12'h341, 32'h1234_5674);

    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b01, 32'h0000_0000);
    cyc();
    rd("mcycleh_carry", 12'hB80, 32'h0000_0001);
    rd("mcycle_wrap", 12'hB00, 32'h0000_0000);
    instret_inc = 1'b1;
    wr(12'hB02, 2'b01, 32'h0000_0010);
    rd("minstret_write_wins", 12'hB02, 32'h0000_0010);
    repeat (3) cyc();
    rd("minstret_count", 12'hB02, 32'h0000_0013);
    instret_inc = 1'b0;
    cyc();

    mret_req = 1'b1;
    cyc();
    chk("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("async_reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("async_reset_redirect_pc", redirect_pc, 32'h0);
    rd("async_reset_mscratch", 12'h340, 32'h0);
    @(negedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    rd("post_reset_mstatus", 12'h300, 32'h0000_1800);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
